awg_sweep_ctrl: RTL and testbench

Sequencer and configuration owner for the triangle/DDS waveform generator. It holds the shadow configuration written by the host or key logic: start/stop frequency, step, dwell, amplitude divisor and phase. On start, it drives the generator's en/state_freq/state_amp/state_phase and steps frequency linearly from f_start to f_stop, holding each step for a programmed dwell. It sits between the control/UI logic and the generator instance.

---
 rtl/awg_pkg.sv | 26 ++
 rtl/awg_dwell_timer.sv | 34 +++
 rtl/awg_sweep_ctrl.sv | 159 +++++++++++++++
 tb/tb_awg_sweep_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/awg_pkg.sv
// Shared constants, config register map and sequencer state encoding
// for the AWG sweep controller.
package awg_pkg;

    localparam int FREQ_W  = 12;
    localparam int AMP_W   = 3;
    localparam int PHASE_W = 8;
    localparam int CFG_W   = 12;
    localparam int DWELL_W = 12;
    localparam int AMP_MIN = 1;

    localparam logic [2:0] REG_F_START = 3'd0;
    localparam logic [2:0] REG_F_STOP  = 3'd1;
    localparam logic [2:0] REG_F_STEP  = 3'd2;
    localparam logic [2:0] REG_DWELL   = 3'd3;
    localparam logic [2:0] REG_AMP     = 3'd4;
    localparam logic [2:0] REG_PHASE   = 3'd5;
    localparam logic [2:0] REG_MODE    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/awg_dwell_timer.sv
// Dwell timer: a prescaler plus dwell-unit counter; tick fires on the last
// cycle of every (dwell+1)*PRESCALE cycle window while run is high.
module awg_dwell_timer #(
    parameter int PRESCALE = 1000,
    parameter int DWELL_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]      pre_cnt;
    logic [DWELL_W-1:0] dwell_cnt;

    assign tick = run && (pre_cnt == PRE_LAST) && (dwell_cnt == dwell);

    always_ff @(posedge clk) begin
        if (rst || clear || !run) begin
            pre_cnt   <= '0;
            dwell_cnt <= '0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt   <= '0;
            dwell_cnt <= (dwell_cnt == dwell) ? '0 : dwell_cnt + 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Sweep sequencer: owns the shadow configuration and drives the generator's
// enable, frequency, amplitude and phase through linear frequency sweeps.
module awg_sweep_ctrl #(
    parameter int PRESCALE = 1000,
    parameter int FREQ_W   = awg_pkg::FREQ_W,
    parameter int AMP_W    = awg_pkg::AMP_W,
    parameter int PHASE_W  = awg_pkg::PHASE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_addr,
    input  logic [11:0]        cfg_wdata,
    input  logic               start,
    input  logic               stop,
    output logic               en,
    output logic [FREQ_W-1:0]  state_freq,
    output logic [AMP_W-1:0]   state_amp,
    output logic [PHASE_W-1:0] state_phase,
    output logic               busy,
    output logic               done
);
    import awg_pkg::*;

    state_t state, state_n;

    logic [FREQ_W-1:0]  sh_start, sh_stop, sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [AMP_W-1:0]   sh_amp;
    logic [PHASE_W-1:0] sh_phase;
    logic               sh_loop;

    // Copy of the sweep parameters captured on entry to RUN; shadow writes
    // during a pass never disturb the pass in progress.
    logic [FREQ_W-1:0]  act_start, act_stop, act_step;
    logic [DWELL_W-1:0] act_dwell;
    logic               act_loop;

    logic               en_n, busy_n, done_n, load, tmr_clear, tick;
    logic [FREQ_W-1:0]  freq_n;
    logic [AMP_W-1:0]   amp_n;
    logic [PHASE_W-1:0] phase_n;
    logic [FREQ_W:0]    freq_sum;

    awg_dwell_timer #(.PRESCALE(PRESCALE), .DWELL_W(DWELL_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .run   (state == ST_RUN),
        .dwell (act_dwell),
        .tick  (tick)
    );

    assign freq_sum = {1'b0, state_freq} + {1'b0, act_step};

    always_comb begin
        state_n   = state;
        en_n      = en;
        busy_n    = busy;
        done_n    = 1'b0;
        freq_n    = state_freq;
        amp_n     = state_amp;
        phase_n   = state_phase;
        load      = 1'b0;
        tmr_clear = 1'b0;
        if (stop) begin
            state_n   = ST_IDLE;
            en_n      = 1'b0;
            busy_n    = 1'b0;
            tmr_clear = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (tick) begin
                        if (state_freq == act_stop || act_stop <= act_start) begin
                            done_n = 1'b1;
                            if (act_loop) begin
                                freq_n = act_start;
                            end else begin
                                state_n = ST_DONE;
                                busy_n  = 1'b0;
                            end
                        end else if (freq_sum[FREQ_W] || freq_sum[FREQ_W-1:0] >= act_stop) begin
                            freq_n = act_stop;
                        end else begin
                            freq_n = freq_sum[FREQ_W-1:0];
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_n   = ST_RUN;
                        en_n      = 1'b1;
                        busy_n    = 1'b1;
                        freq_n    = sh_start;
                        amp_n     = sh_amp;
                        phase_n   = sh_phase;
                        load      = 1'b1;
                        tmr_clear = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            en          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            state_freq  <= '0;
            state_amp   <= AMP_W'(AMP_MIN);
            state_phase <= '0;
            sh_start    <= '0;
            sh_stop     <= '0;
            sh_step     <= FREQ_W'(1);
            sh_dwell    <= '0;
            sh_amp      <= AMP_W'(AMP_MIN);
            sh_phase    <= '0;
            sh_loop     <= 1'b0;
            act_start   <= '0;
            act_stop    <= '0;
            act_step    <= FREQ_W'(1);
            act_dwell   <= '0;
            act_loop    <= 1'b0;
        end else begin
            state       <= state_n;
            en          <= en_n;
            busy        <= busy_n;
            done        <= done_n;
            state_freq  <= freq_n;
            state_amp   <= amp_n;
            state_phase <= phase_n;
            if (load) begin
                act_start <= sh_start;
                act_stop  <= sh_stop;
                act_step  <= sh_step;
                act_dwell <= sh_dwell;
                act_loop  <= sh_loop;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    REG_F_START: sh_start <= cfg_wdata[FREQ_W-1:0];
                    REG_F_STOP:  sh_stop  <= cfg_wdata[FREQ_W-1:0];
                    REG_F_STEP:  sh_step  <= (cfg_wdata[FREQ_W-1:0] == '0) ? FREQ_W'(1)
                                                                           : cfg_wdata[FREQ_W-1:0];
                    REG_DWELL:   sh_dwell <= cfg_wdata[DWELL_W-1:0];
                    REG_AMP:     sh_amp   <= (cfg_wdata[AMP_W-1:0] == '0) ? AMP_W'(AMP_MIN)
                                                                          : cfg_wdata[AMP_W-1:0];
                    REG_PHASE:   sh_phase <= cfg_wdata[PHASE_W-1:0];
                    REG_MODE:    sh_loop  <= cfg_wdata[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Directed bench for awg_sweep_ctrl: table of single-pass sweeps plus
// hand sequences for loop mode, stop priority, shadow guards and reset.
module tb_awg_sweep_ctrl;
    import awg_pkg::*;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start, stop;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic        en, busy, done;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;

    awg_sweep_ctrl #(.PRESCALE(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .start       (start),
        .stop        (stop),
        .en          (en),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]       fs, fe, st, dw;
        logic [2:0]        amp, amp_exp;
        logic [7:0]        ph;
        int                n;
        logic [3:0][11:0]  f;
    } vec_t;

    vec_t tbl[4];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] stat(logic e, logic b, logic d, logic [11:0] f);
        return {17'b0, e, b, d, f};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [11:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Checks {en,busy,done,freq} for n consecutive cycles; done expected only on the first.
    task automatic hold(input string nm, input int n, input logic e, input logic b,
                        input logic [11:0] f, input logic d0);
        for (int c = 0; c < n; c++) begin
            chk($sformatf("%s c%0d", nm, c), stat(en, busy, done, state_freq),
                stat(e, b, (c == 0) ? d0 : 1'b0, f));
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; start = 1'b0; stop = 1'b0;

        tbl[0] = '{fs:12'd100,  fe:12'd130,  st:12'd10, dw:12'd1, amp:3'd5, amp_exp:3'd5,
                   ph:8'h3C, n:4, f:{12'd130, 12'd120, 12'd110, 12'd100}};
        tbl[1] = '{fs:12'd4090, fe:12'd4095, st:12'd20, dw:12'd0, amp:3'd0, amp_exp:3'd1,
                   ph:8'h80, n:2, f:{12'd0, 12'd0, 12'd4095, 12'd4090}};
        tbl[2] = '{fs:12'd60,   fe:12'd50,   st:12'd5,  dw:12'd2, amp:3'd3, amp_exp:3'd3,
                   ph:8'h01, n:1, f:{12'd0, 12'd0, 12'd0, 12'd60}};
        tbl[3] = '{fs:12'd0,    fe:12'd3,    st:12'd0,  dw:12'd0, amp:3'd7, amp_exp:3'd7,
                   ph:8'hFF, n:4, f:{12'd3, 12'd2, 12'd1, 12'd0}};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset status", stat(en, busy, done, state_freq), stat(0, 0, 0, 12'd0));
        chk("reset amp", 32'(state_amp), 32'd1);
        chk("reset phase", 32'(state_phase), 32'd0);

        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("start+stop idle", stat(en, busy, done, state_freq), stat(0, 0, 0, 12'd0));

        for (int i = 0; i < 4; i++) begin
            wr(REG_F_START, tbl[i].fs);
            wr(REG_F_STOP,  tbl[i].fe);
            wr(REG_F_STEP,  tbl[i].st);
            wr(REG_DWELL,   tbl[i].dw);
            wr(REG_AMP,     12'(tbl[i].amp));
            wr(REG_PHASE,   12'(tbl[i].ph));
            wr(REG_MODE,    12'd0);
            pulse_start();
            chk($sformatf("v%0d amp", i), 32'(state_amp), 32'(tbl[i].amp_exp));
            chk($sformatf("v%0d phase", i), 32'(state_phase), 32'(tbl[i].ph));
            for (int k = 0; k < tbl[i].n; k++)
                hold($sformatf("v%0d s%0d", i, k), (int'(tbl[i].dw) + 1) * P, 1'b1, 1'b1,
                     tbl[i].f[k], 1'b0);
            chk($sformatf("v%0d done", i), stat(en, busy, done, state_freq),
                stat(1, 0, 1, tbl[i].f[tbl[i].n-1]));
            @(negedge clk);
            chk($sformatf("v%0d hold", i), stat(en, busy, done, state_freq),
                stat(1, 0, 0, tbl[i].f[tbl[i].n-1]));
            pulse_stop();
            chk($sformatf("v%0d stop", i), stat(en, busy, done, state_freq),
                stat(0, 0, 0, tbl[i].f[tbl[i].n-1]));
        end

        // Loop mode: done pulses on each reload while busy stays high.
        wr(REG_F_START, 12'd10); wr(REG_F_STOP, 12'd20); wr(REG_F_STEP, 12'd10);
        wr(REG_DWELL, 12'd0); wr(REG_MODE, 12'd1);
        pulse_start();
        for (int p = 0; p < 3; p++) begin
            hold($sformatf("loop p%0d lo", p), P, 1'b1, 1'b1, 12'd10, p > 0);
            hold($sformatf("loop p%0d hi", p), P, 1'b1, 1'b1, 12'd20, 1'b0);
        end
        hold("loop reload", 1, 1'b1, 1'b1, 12'd10, 1'b1);
        pulse_stop();

        // Stop lands on the tick cycle: no step, no done.
        wr(REG_F_START, 12'd100); wr(REG_F_STOP, 12'd130); wr(REG_F_STEP, 12'd10);
        wr(REG_MODE, 12'd0);
        pulse_start();
        repeat (P - 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop on tick", stat(en, busy, done, state_freq), stat(0, 0, 0, 12'd100));
        @(negedge clk);
        chk("stop settle", stat(en, busy, done, state_freq), stat(0, 0, 0, 12'd100));

        // Zero writes mid-pass land in shadow only, then take effect on restart.
        wr(REG_F_START, 12'd200); wr(REG_F_STOP, 12'd260); wr(REG_F_STEP, 12'd30);
        wr(REG_AMP, 12'd5);
        pulse_start();
        wr(REG_AMP, 12'd0);
        wr(REG_F_STEP, 12'd0);
        chk("shadow amp mid", 32'(state_amp), 32'd5);
        repeat (P - 2) @(negedge clk);
        chk("shadow old step", 32'(state_freq), 32'd230);
        chk("shadow amp held", 32'(state_amp), 32'd5);
        pulse_stop();
        pulse_start();
        chk("restart amp", 32'(state_amp), 32'd1);
        hold("restart s0", P, 1'b1, 1'b1, 12'd200, 1'b0);
        chk("restart step1", stat(en, busy, done, state_freq), stat(1, 1, 0, 12'd201));

        // Reset mid-RUN wipes outputs and shadow config.
        rst = 1'b1;
        @(negedge clk);
        chk("rst mid status", stat(en, busy, done, state_freq), stat(0, 0, 0, 12'd0));
        chk("rst mid amp", 32'(state_amp), 32'd1);
        chk("rst mid phase", 32'(state_phase), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulse_start();
        chk("post-rst amp", 32'(state_amp), 32'd1);
        hold("post-rst s0", P, 1'b1, 1'b1, 12'd0, 1'b0);
        chk("post-rst done", stat(en, busy, done, state_freq), stat(1, 0, 1, 12'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
